// File: rtl/demux1x2_tdm.sv
// ---------------------------------------------------------------------------
// demux1x2_tdm
//
// Two-channel time-division demultiplexer. This is the receive side of a
// mux2x1-driven link. The input stream alternates channel-0 and channel-1
// words. A frame-sync marker on a valid word identifies that word as
// channel 0. The block captures the channel-0 word, waits for its
// channel-1 partner, and then presents both words together with a
// one-cycle valid strobe.
//
// Parameters:
//   WIDTH       bit width of each channel word
//   CNT_W       width of the completed-pair counter
//
// Ports:
//   clk         rising-edge clock for all state
//   rst_n       asynchronous active-low reset; clears all state and outputs
//   din         multiplexed data word
//   din_valid   din is valid this cycle (nothing happens without it)
//   sync        qualified by din_valid; marks din as a channel-0 word
//   dout0       last completed channel-0 word (holds between strobes)
//   dout1       last completed channel-1 word (holds between strobes)
//   dout_valid  one-cycle strobe: dout0/dout1 were just updated
//   slot        channel expected for the next accepted word (0/1)
//   locked      a sync has been seen and slots are being tracked
//   err         sticky misalignment flag (sync seen where ch1 was due)
//   frame_cnt   number of completed pairs, wraps modulo 2^CNT_W
//
// Every output is either a register or a direct decode of the state
// register. No input reaches an output combinationally.
// ---------------------------------------------------------------------------
module demux1x2_tdm #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] dout0,
    output logic [WIDTH-1:0] dout1,
    output logic             dout_valid,
    output logic             slot,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] frame_cnt
);

    // HUNT  : waiting for a sync-marked word; non-sync words are dropped.
    // SLOT0 : aligned, the next accepted word is channel 0.
    // SLOT1 : aligned, a channel-0 word is held in stage0 and its
    //         channel-1 partner is due next.
    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SLOT0 = 2'd1,
        SLOT1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // Holds the channel-0 word until its channel-1 partner arrives, so that
    // dout0 and dout1 change together on the same edge.
    logic [WIDTH-1:0] stage0;
    logic [WIDTH-1:0] stage0_nxt;

    logic [WIDTH-1:0] dout0_nxt;
    logic [WIDTH-1:0] dout1_nxt;
    logic             dout_valid_nxt;
    logic             err_nxt;
    logic [CNT_W-1:0] frame_cnt_nxt;

    // -----------------------------------------------------------------------
    // State register and datapath registers
    // -----------------------------------------------------------------------
    // NOTE: every register, including the stage0 holding register, is
    // cleared by the asynchronous reset so that a reset mid-frame leaves no
    // partial pair behind; the new frame must start from a fresh sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            stage0     <= '0;
            dout0      <= '0;
            dout1      <= '0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the values computed from the pre-edge state; blocking ones
            // would make the result depend on statement order.
            state      <= state_nxt;
            stage0     <= stage0_nxt;
            dout0      <= dout0_nxt;
            dout1      <= dout1_nxt;
            dout_valid <= dout_valid_nxt;
            err        <= err_nxt;
            frame_cnt  <= frame_cnt_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-value logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written below gets a hold value first, so no
        // path through the case statement can leave one unassigned and
        // infer a latch.
        state_nxt      = state;
        stage0_nxt     = stage0;
        dout0_nxt      = dout0;
        dout1_nxt      = dout1;
        dout_valid_nxt = 1'b0;   // strobe lasts one cycle unless re-asserted
        err_nxt        = err;    // sticky: only reset clears it
        frame_cnt_nxt  = frame_cnt;

        // Without din_valid nothing moves; sync is meaningless on an
        // invalid cycle, so idle gaps never disturb alignment.
        if (din_valid) begin
            unique case (state)
                HUNT: begin
                    // Only a sync-marked word can start a frame.
                    if (sync) begin
                        stage0_nxt = din;
                        state_nxt  = SLOT1;
                    end
                end

                SLOT0: begin
                    // A sync here agrees with our alignment, so it is
                    // accepted exactly like an unmarked channel-0 word.
                    stage0_nxt = din;
                    state_nxt  = SLOT1;
                end

                SLOT1: begin
                    if (sync) begin
                        // The link says this is channel 0 but a channel-1
                        // word was due. Trust the marker: drop the pending
                        // word, restart the pair from din and flag it.
                        err_nxt    = 1'b1;
                        stage0_nxt = din;
                        state_nxt  = SLOT1;
                    end else begin
                        // Pair complete: publish both words together.
                        dout0_nxt      = stage0;
                        dout1_nxt      = din;
                        dout_valid_nxt = 1'b1;
                        frame_cnt_nxt  = frame_cnt + CNT_W'(1);
                        state_nxt      = SLOT0;
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to searching for sync.
                    state_nxt = HUNT;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Decoded status outputs (straight from the state register)
    // -----------------------------------------------------------------------
    assign locked = (state != HUNT);
    assign slot   = (state == SLOT1);

endmodule

// File: doc/demux1x2_tdm.md
# demux1x2_tdm

Two-channel time-division demultiplexer: the receive-side counterpart of the 2:1 multiplexer. A single serial word stream, built by alternating the multiplexer select between channel 0 and channel 1, is split back into two parallel channel outputs. A frame-sync marker aligns the block to channel 0. Completed pairs are presented together with a one-cycle valid strobe. The block sits directly downstream of a mux2x1-driven link.

## Interface
Parameters:
- WIDTH, 1, bit width of each channel word
- CNT_W, 8, width of the frame counter

Ports:
- clk  input  1  rising-edge clock for all state
- rst_n  input  1  asynchronous, active-low reset; clears all state and outputs
- din  input  WIDTH  multiplexed data word
- din_valid  input  1  din is valid this cycle
- sync  input  1  qualified by din_valid; marks din as a channel-0 word
- dout0  output  WIDTH  last completed channel-0 word
- dout1  output  WIDTH  last completed channel-1 word
- dout_valid  output  1  one-cycle strobe: dout0/dout1 updated
- slot  output  1  channel expected for the next accepted word (0/1)
- locked  output  1  block has seen a sync and is tracking slots
- err  output  1  sticky misalignment flag
- frame_cnt  output  CNT_W  number of completed pairs, wraps modulo 2^CNT_W

## Operation
- The FSM has three states: HUNT, SLOT0, SLOT1. Reset state is HUNT.
- A word is accepted only on a rising edge with din_valid=1. When din_valid=0, sync is ignored and no state changes.
- HUNT:
  - din_valid & sync: capture din into stage0, go to SLOT1.
  - din_valid & !sync: drop the word, stay in HUNT.
- SLOT0: accept din with or without sync, capture into stage0, go to SLOT1.
- SLOT1:
  - din_valid & !sync:
    - dout0 <= stage0, dout1 <= din.
    - dout_valid <= 1.
    - frame_cnt <= frame_cnt + 1, wrapping from all-ones to 0.
    - Go to SLOT0.
  - din_valid & sync (misalignment):
    - err <= 1.
    - The pending stage0 word is discarded; din is captured into stage0 as the new channel-0 word.
    - Stay in SLOT1. No dout_valid.
- Output decodes:
  - locked = (state != HUNT).
  - slot = 1 in SLOT1, else 0.
- err stays set until reset. No input clears it.
- dout0 and dout1 hold their values between strobes. They never change without dout_valid.
- Asynchronous reset mid-frame discards any partial pair. The block returns to HUNT and must see a new sync.

## Timing
- Reset values:
  - dout0 = 0, dout1 = 0.
  - dout_valid = 0, slot = 0, locked = 0.
  - err = 0, frame_cnt = 0.
  - Internal: stage0 = 0, state = HUNT.
- All outputs are registered or decoded directly from registered state. There is no combinational path from inputs to outputs.
- Latency: the edge that accepts the channel-1 word updates dout0, dout1, dout_valid and frame_cnt together. dout_valid is high for exactly the following cycle, then returns to 0 unless the next edge completes another pair.
- Throughput: one word per cycle at most, one pair every two accepted words. Back-to-back pairs give dout_valid high in alternating cycles.
- Gaps are allowed: din_valid=0 cycles between words do not affect alignment.
- slot, locked and err update on the same edge as the state transition that causes them.
- rst_n assertion clears outputs immediately, without waiting for clk. Deassertion is sampled at the next rising edge.

## Test plan
- Reset and hunt:
  - Stimulus: hold rst_n=0, then release. Send din=1 with din_valid=1, sync=0 for 3 cycles.
  - Required: all outputs stay 0, locked=0, no dout_valid.
- Basic pair:
  - Stimulus: word (din=1, sync=1), then word (din=0, sync=0).
  - Required: one cycle after the second edge, dout0=1, dout1=0, dout_valid=1 for one cycle, frame_cnt=1, slot=0, locked=1.
- Free-running stream with gaps:
  - Stimulus: after lock, send words 0,1 / 1,1 / 1,0 (pairs as ch0,ch1) without sync, with one idle cycle (din_valid=0) between each word.
  - Required: three strobes with (0,1), (1,1), (1,0). frame_cnt goes to 4 counting the prior pair. Outputs hold during gaps.
- Misalignment:
  - Stimulus: in SLOT1, send din=1 with sync=1, then din=0 with sync=0.
  - Required: err=1 after the first edge and no strobe. Then a strobe with dout0=1, dout1=0. err remains 1.
- Counter wrap (CNT_W=8):
  - Stimulus: complete 256 pairs.
  - Required: frame_cnt reads 255 after pair 255 and 0 after pair 256. dout_valid is correct throughout.
- Reset mid-frame:
  - Stimulus: in SLOT1 with stage0=1, pulse rst_n low between clock edges, then send din=0, sync=0.
  - Required: outputs clear immediately, locked=0. The post-reset word is dropped, with no strobe.
